// File: rtl/gcode_move_sequencer.sv
// Move sequencer: resolves G-code targets to absolute machine positions and drives
// per-axis step/dir pulses (independent rapid or Bresenham linear), plus pen and tool handshakes.
module gcode_move_sequencer #(
  parameter int COORD_W  = 14,
  parameter int STEP_DIV = 1000,
  parameter int INCH_MUL = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [4:0]         state_reg,
  input  logic [COORD_W-1:0] x_value,
  input  logic [COORD_W-1:0] y_value,
  input  logic               tool_ack,
  output logic               controller_ready,
  output logic               step_x,
  output logic               step_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               pen_up,
  output logic               tool_req,
  output logic [COORD_W-1:0] tool_num,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y
);
  localparam int WI    = COORD_W + 6;
  localparam int EW    = COORD_W + 2;
  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0]     TICK_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic signed [WI-1:0] INCH_MUL_S = WI'(INCH_MUL);
  localparam logic signed [WI-1:0] POS_MAX    = WI'((1 << COORD_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_PLAN, S_DIR_SETUP, S_MOVE, S_TOOL} fsm_t;

  fsm_t                   fsm_reg, fsm_next;
  logic                   ready_reg, ack_reg;
  logic                   linear_reg, inches_reg, abs_reg, tool_reg;
  logic [COORD_W-1:0]     x_val_reg, y_val_reg;
  logic [CNT_W-1:0]       tick_cnt_reg;
  logic                   step_x_reg, step_y_reg, dir_x_reg, dir_y_reg;
  logic                   pen_up_reg, tool_req_reg;
  logic [COORD_W-1:0]     tool_num_reg, pos_x_reg, pos_y_reg;
  logic [COORD_W-1:0]     rem_x_reg, rem_y_reg, major_reg, minor_reg;
  logic                   x_major_reg;
  logic signed [EW-1:0]   err_reg;

  logic                   accept, tick, move_done, minor_step;
  logic                   step_x_d, step_y_d, x_major_w;
  logic [COORD_W-1:0]     tgt_x, tgt_y, dist_x, dist_y, major_w, minor_w;
  logic signed [EW-1:0]   err_dec, err_next;

  // Absolute values are unsigned; relative deltas are two's complement. Result clamped to the bed.
  function automatic logic [COORD_W-1:0] resolve(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] pos,
    input logic               absolute,
    input logic               inches
  );
    logic signed [WI-1:0] ext;
    logic signed [WI-1:0] scaled;
    logic signed [WI-1:0] t;
    ext    = absolute ? $signed({6'b0, v}) : $signed({{6{v[COORD_W-1]}}, v});
    scaled = inches ? ext * INCH_MUL_S : ext;
    t      = absolute ? scaled : $signed({6'b0, pos}) + scaled;
    if (t[WI-1]) return '0;
    if (t > POS_MAX) return POS_MAX[COORD_W-1:0];
    return t[COORD_W-1:0];
  endfunction

  always_comb begin
    fsm_next   = fsm_reg;
    accept     = cmd_valid && ready_reg;
    tgt_x      = resolve(x_val_reg, pos_x_reg, abs_reg, inches_reg);
    tgt_y      = resolve(y_val_reg, pos_y_reg, abs_reg, inches_reg);
    dist_x     = (tgt_x >= pos_x_reg) ? tgt_x - pos_x_reg : pos_x_reg - tgt_x;
    dist_y     = (tgt_y >= pos_y_reg) ? tgt_y - pos_y_reg : pos_y_reg - tgt_y;
    x_major_w  = (dist_x >= dist_y);
    major_w    = x_major_w ? dist_x : dist_y;
    minor_w    = x_major_w ? dist_y : dist_x;
    tick       = (tick_cnt_reg == TICK_LAST);
    move_done  = (rem_x_reg == '0) && (rem_y_reg == '0);
    err_dec    = err_reg - $signed({2'b0, minor_reg});
    err_next   = err_reg;
    minor_step = 1'b0;
    step_x_d   = 1'b0;
    step_y_d   = 1'b0;

    if (fsm_reg == S_MOVE && tick && !move_done) begin
      if (linear_reg) begin
        minor_step = err_dec[EW-1];
        err_next   = minor_step ? err_dec + $signed({2'b0, major_reg}) : err_dec;
        step_x_d   = x_major_reg | minor_step;
        step_y_d   = !x_major_reg | minor_step;
      end else begin
        step_x_d = (rem_x_reg != '0);
        step_y_d = (rem_y_reg != '0);
      end
    end

    case (fsm_reg)
      S_IDLE:      if (accept) fsm_next = S_PLAN;
      S_PLAN: begin
        if (tool_reg)                            fsm_next = S_TOOL;
        else if (dist_x == '0 && dist_y == '0)   fsm_next = S_IDLE;
        else                                     fsm_next = S_DIR_SETUP;
      end
      S_DIR_SETUP: if (tick) fsm_next = S_MOVE;
      S_MOVE:      if (move_done) fsm_next = S_IDLE;
      S_TOOL:      if (ack_reg) fsm_next = S_IDLE;
      default:     fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_reg <= S_IDLE;
    else        fsm_reg <= fsm_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg    <= 1'b1;
      ack_reg      <= 1'b0;
      linear_reg   <= 1'b0;
      inches_reg   <= 1'b0;
      abs_reg      <= 1'b0;
      tool_reg     <= 1'b0;
      x_val_reg    <= '0;
      y_val_reg    <= '0;
      tick_cnt_reg <= '0;
      step_x_reg   <= 1'b0;
      step_y_reg   <= 1'b0;
      dir_x_reg    <= 1'b0;
      dir_y_reg    <= 1'b0;
      pen_up_reg   <= 1'b0;
      tool_req_reg <= 1'b0;
      tool_num_reg <= '0;
      pos_x_reg    <= '0;
      pos_y_reg    <= '0;
      rem_x_reg    <= '0;
      rem_y_reg    <= '0;
      major_reg    <= '0;
      minor_reg    <= '0;
      x_major_reg  <= 1'b1;
      err_reg      <= '0;
    end else begin
      // Ready lags the state by one clock so upstream sees a clean registered handshake.
      ready_reg  <= (fsm_reg == S_IDLE) && !accept;
      ack_reg    <= tool_ack;
      step_x_reg <= step_x_d;
      step_y_reg <= step_y_d;

      if (fsm_reg == S_PLAN || tick)
        tick_cnt_reg <= '0;
      else if (fsm_reg == S_DIR_SETUP || fsm_reg == S_MOVE)
        tick_cnt_reg <= tick_cnt_reg + 1'b1;

      case (fsm_reg)
        S_IDLE: begin
          if (accept) begin
            linear_reg <= state_reg[0];
            inches_reg <= state_reg[1];
            abs_reg    <= state_reg[2];
            pen_up_reg <= state_reg[3];
            tool_reg   <= state_reg[4];
            x_val_reg  <= x_value;
            y_val_reg  <= y_value;
          end
        end
        S_PLAN: begin
          if (tool_reg) begin
            tool_num_reg <= x_val_reg;
            tool_req_reg <= 1'b1;
          end else begin
            dir_x_reg   <= (tgt_x >= pos_x_reg);
            dir_y_reg   <= (tgt_y >= pos_y_reg);
            rem_x_reg   <= dist_x;
            rem_y_reg   <= dist_y;
            x_major_reg <= x_major_w;
            major_reg   <= major_w;
            minor_reg   <= minor_w;
            err_reg     <= $signed({3'b0, major_w[COORD_W-1:1]});
          end
        end
        S_MOVE: begin
          if (step_x_d) begin
            pos_x_reg <= dir_x_reg ? pos_x_reg + 1'b1 : pos_x_reg - 1'b1;
            rem_x_reg <= rem_x_reg - 1'b1;
          end
          if (step_y_d) begin
            pos_y_reg <= dir_y_reg ? pos_y_reg + 1'b1 : pos_y_reg - 1'b1;
            rem_y_reg <= rem_y_reg - 1'b1;
          end
          err_reg <= err_next;
        end
        S_TOOL: if (ack_reg) tool_req_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign controller_ready = ready_reg;
  assign step_x           = step_x_reg;
  assign step_y           = step_y_reg;
  assign dir_x            = dir_x_reg;
  assign dir_y            = dir_y_reg;
  assign pen_up           = pen_up_reg;
  assign tool_req         = tool_req_reg;
  assign tool_num         = tool_num_reg;
  assign pos_x            = pos_x_reg;
  assign pos_y            = pos_y_reg;

endmodule

// File: tb/tb_gcode_move_sequencer.sv
// Scoreboard bench: stimulus pushes model-derived expectations; a monitor counts step
// pulses and busy cycles and compares them at each command completion.
module tb_gcode_move_sequencer;
  localparam int SD      = 4;
  localparam int TIMEOUT = 3000;

  logic        clk, rst_n, cmd_valid, tool_ack;
  logic [4:0]  state_reg;
  logic [13:0] x_value, y_value;
  logic        controller_ready, step_x, step_y, dir_x, dir_y, pen_up, tool_req;
  logic [13:0] tool_num, pos_x, pos_y;

  gcode_move_sequencer #(.COORD_W(14), .STEP_DIV(SD), .INCH_MUL(25)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .state_reg(state_reg),
    .x_value(x_value), .y_value(y_value), .tool_ack(tool_ack),
    .controller_ready(controller_ready), .step_x(step_x), .step_y(step_y),
    .dir_x(dir_x), .dir_y(dir_y), .pen_up(pen_up), .tool_req(tool_req),
    .tool_num(tool_num), .pos_x(pos_x), .pos_y(pos_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           px, py, nsx, nsy, busy, pen, dirx, diry;
    bit           x_major;
    logic [127:0] mask;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   pos_x_m = 0, pos_y_m = 0, dir_x_m = 0, dir_y_m = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int resolve_m(int raw, int pos, bit absolute, bit inches);
    int v, t;
    v = raw;
    if (!absolute && raw >= 8192) v = raw - 16384;
    if (inches) v = v * 25;
    t = absolute ? v : pos + v;
    if (t < 0) t = 0;
    if (t > 16383) t = 16383;
    return t;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (controller_ready !== 1'b1) begin
      if (n == TIMEOUT) begin
        chk("ready_timeout", 0, 1);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Model a command, queue its expected outcome, then present it for one accepting edge.
  task automatic issue(input logic [4:0] m, input logic [13:0] xv, input logic [13:0] yv,
                       input int tool_busy);
    exp_t e;
    int tx, ty, dxa, dya, mj, mn, h, need, mk, mprev;
    wait_ready();
    e.mask    = '0;
    e.pen     = m[3];
    e.x_major = 1'b1;
    if (m[4]) begin
      e.nsx = 0; e.nsy = 0; e.busy = tool_busy;
    end else begin
      tx  = resolve_m(int'(xv), pos_x_m, m[2], m[1]);
      ty  = resolve_m(int'(yv), pos_y_m, m[2], m[1]);
      dxa = (tx >= pos_x_m) ? tx - pos_x_m : pos_x_m - tx;
      dya = (ty >= pos_y_m) ? ty - pos_y_m : pos_y_m - ty;
      dir_x_m = (tx >= pos_x_m);
      dir_y_m = (ty >= pos_y_m);
      e.x_major = (dxa >= dya);
      mj = e.x_major ? dxa : dya;
      mn = e.x_major ? dya : dxa;
      // Bit k-1 set when the minor axis steps together with the k-th major step.
      if (m[0]) begin
        h = mj / 2;
        mprev = 0;
        for (int k = 1; k <= mj; k++) begin
          need = k * mn - h;
          mk = (need <= 0) ? 0 : (need + mj - 1) / mj;
          if (mk > mprev) e.mask[k-1] = 1'b1;
          mprev = mk;
        end
      end else begin
        for (int k = 1; k <= mn; k++) e.mask[k-1] = 1'b1;
      end
      e.nsx  = dxa;
      e.nsy  = dya;
      e.busy = (mj == 0) ? 2 : 3 + SD * (mj + 1);
      pos_x_m = tx;
      pos_y_m = ty;
    end
    e.px = pos_x_m; e.py = pos_y_m; e.dirx = dir_x_m; e.diry = dir_y_m;
    q.push_back(e);
    state_reg = m; x_value = xv; y_value = yv; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    int busy = 0, nsx = 0, nsy = 0, lone = 0, kcnt = 0, txn = 0;
    logic [127:0] mask = '0;
    bit maj, mnr;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        busy = 0; nsx = 0; nsy = 0; lone = 0; kcnt = 0; mask = '0;
      end else begin
        if (!controller_ready) busy++;
        if (step_x) nsx++;
        if (step_y) nsy++;
        if ((step_x || step_y) && q.size() > 0) begin
          maj = q[0].x_major ? step_x : step_y;
          mnr = q[0].x_major ? step_y : step_x;
          if (maj) begin
            if (mnr && kcnt < 128) mask[kcnt] = 1'b1;
            kcnt++;
          end else lone++;
        end
        if (controller_ready && busy > 0) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: got 1 completion expected 0");
          end else begin
            e = q.pop_front();
            txn++;
            $display("txn %0d: pos=(%0d,%0d) steps=(%0d,%0d) busy=%0d dir=(%0d,%0d)",
                     txn, pos_x, pos_y, nsx, nsy, busy, dir_x, dir_y);
            chk("pos_x", pos_x, e.px);
            chk("pos_y", pos_y, e.py);
            chk("steps_x", nsx, e.nsx);
            chk("steps_y", nsy, e.nsy);
            chk("pen_up", pen_up, e.pen);
            chk("dir_x", dir_x, e.dirx);
            chk("dir_y", dir_y, e.diry);
            chk("lone_minor_steps", lone, 0);
            if (e.busy >= 0) chk("busy_cycles", busy, e.busy);
            checks++;
            if (mask !== e.mask) begin
              errors++;
              $display("FAIL step_pairing: got %h expected %h", mask, e.mask);
            end
          end
          busy = 0; nsx = 0; nsy = 0; lone = 0; kcnt = 0; mask = '0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; tool_ack = 1'b0;
    state_reg = '0; x_value = '0; y_value = '0;
    #12;
    chk("reset_ready", controller_ready, 1);
    chk("reset_pos_x", pos_x, 0);
    chk("reset_pos_y", pos_y, 0);
    chk("reset_steps", {step_x, step_y}, 0);
    chk("reset_tool_req", tool_req, 0);
    chk("reset_pen_up", pen_up, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    issue(5'b00100, 14'd3, 14'd5, -1);        // absolute rapid to (3,5)
    issue(5'b00000, 14'h3FF6, 14'd2, -1);     // relative -10,+2 -> clamped (0,7)
    issue(5'b00100, 14'd0, 14'd0, -1);
    issue(5'b00101, 14'd8, 14'd4, -1);        // linear to (8,4)
    issue(5'b00100, 14'd0, 14'd0, -1);
    issue(5'b00110, 14'd2, 14'd1, -1);        // inches -> (50,25)
    issue(5'b00101, 14'd47, 14'd60, -1);      // y-major linear

    // Tool change with a late acknowledge
    issue(5'b10000, 14'd7, 14'd0, -1);
    repeat (4) begin @(posedge clk); #1; end
    chk("tool_req_high", tool_req, 1);
    chk("tool_num", tool_num, 7);
    chk("tool_ready_low", controller_ready, 0);
    tool_ack = 1'b1;
    @(posedge clk); #1; chk("tool_ready_ack1", controller_ready, 0);
    @(posedge clk); #1; chk("tool_ready_ack2", controller_ready, 0);
    @(posedge clk); #1; chk("tool_ready_ack3", controller_ready, 1);
    chk("tool_req_dropped", tool_req, 0);
    tool_ack = 1'b0;

    // Acknowledge already high before entering TOOL
    tool_ack = 1'b1;
    issue(5'b11000, 14'd3, 14'd9, 3);
    wait_ready();
    chk("tool_num_2", tool_num, 3);
    tool_ack = 1'b0;

    issue(5'b00100, 14'(pos_x_m), 14'(pos_y_m), -1);   // zero-length move

    for (int i = 0; i < 20; i++) begin
      logic [4:0]  m;
      logic [13:0] xv, yv;
      int dxr, dyr;
      m[0] = 1'($urandom_range(0, 1));
      m[1] = 1'($urandom_range(0, 1));
      m[2] = 1'($urandom_range(0, 1));
      m[3] = 1'($urandom_range(0, 1));
      m[4] = 1'b0;
      if (pos_x_m > 90 || pos_y_m > 90) m[2] = 1'b1;
      if (m[2]) begin
        xv = m[1] ? 14'($urandom_range(0, 3)) : 14'($urandom_range(0, 40));
        yv = m[1] ? 14'($urandom_range(0, 3)) : 14'($urandom_range(0, 40));
      end else begin
        dxr = m[1] ? int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 40)) - 20;
        dyr = m[1] ? int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 40)) - 20;
        xv = 14'(dxr);
        yv = 14'(dyr);
      end
      issue(m, xv, yv, -1);
    end

    wait_ready();
    repeat (2) begin @(posedge clk); #1; end
    chk("queue_drained", q.size(), 0);

    // Reset in the middle of a move, while a step pulse is high
    mon_en = 1'b0;
    state_reg = 5'b01101; x_value = 14'd60; y_value = 14'd30; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (step_x !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midmove_step_seen", step_x, 1);
    chk("midmove_pen_up", pen_up, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", controller_ready, 1);
    chk("async_rst_step", {step_x, step_y}, 0);
    chk("async_rst_dir", {dir_x, dir_y}, 0);
    chk("async_rst_pen", pen_up, 0);
    chk("async_rst_pos_x", pos_x, 0);
    chk("async_rst_pos_y", pos_y, 0);
    chk("async_rst_tool", {tool_req, tool_num}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcode_move_sequencer.md
Name: gcode_move_sequencer

Overview:
- Downstream consumer of the G-code controller interface. Takes its mode bits and 14-bit X/Y targets, resolves each target to an absolute position (absolute/relative, inch/mm), and drives one-clock step/dir pulses per axis.
- Rapid moves (G00) step each axis independently. Linear moves (G01) use Bresenham interpolation.
- Also handles pen raise and tool-change handshakes.
- Produces the `controller_ready` signal that upstream uses to release the next command.

Parameters:
- COORD_W, 14: coordinate width in machine units (unsigned position, 0..2^COORD_W-1).
- STEP_DIV, 1000: clock cycles per step tick (≥2).
- INCH_MUL, 25: machine units per input unit when inches mode is set.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  upstream command available (controller_interface_out_ready)
- state_reg  in  5  {tool_change, raise_tool, absolute, inches, linear}, bit4..bit0
- x_value  in  COORD_W  X target / delta (two's complement in relative mode); tool number on tool change
- y_value  in  COORD_W  Y target / delta
- tool_ack  in  1  tool change complete (level)
- controller_ready  out  1  idle, can accept a command
- step_x, step_y  out  1  one-clock step pulse
- dir_x, dir_y  out  1  1 = increasing position
- pen_up  out  1  tool raised
- tool_req  out  1  tool change request
- tool_num  out  COORD_W  requested tool number
- pos_x, pos_y  out  COORD_W  current position

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - controller_ready=1.
  - All step/dir/pen_up/tool_req = 0.
  - tool_num, pos_x, pos_y = 0.
  - Tick counter = 0.
- Registered outputs only. `controller_ready` = (state==IDLE).
- Accept: rising clk with cmd_valid && controller_ready latches state_reg, x_value and y_value. The next state is PLAN. Inputs are ignored while not IDLE.
- pen_up updates to state_reg[3] on every accept.
- PLAN (1 cycle): compute targets with COORD_W+6-bit signed intermediates.
  - Inches: v = v*INCH_MUL.
  - Absolute: target = v.
  - Relative: target = pos + sign-extended v.
  - Clamp target to [0, 2^COORD_W-1].
  - dir = (target ≥ pos).
  - dx = |tx-px|, dy = |ty-py|.
  - Next state:
    - tool_change=1 → TOOL.
    - dx=dy=0 → IDLE (ready returns 2 clocks after accept).
    - Otherwise → DIR_SETUP.
- DIR_SETUP: dir_x/dir_y are valid. The tick counter is cleared on entry. Wait one full tick (STEP_DIV clocks), then go to MOVE.
- Tick: in MOVE, the counter runs 0..STEP_DIV-1. A tick fires when it reaches STEP_DIV-1, then the counter wraps to 0.
- MOVE, rapid (linear=0): on each tick, each axis with remaining distance >0 pulses its step for one clock and moves pos by ±1.
- MOVE, linear (linear=1):
  - Major axis = larger of dx/dy; ties go to X.
  - err initialised to major/2 in PLAN.
  - Each tick: step major; err -= minor; if err<0, also step minor in the same clock and err += major.
  - Exactly max(dx,dy) ticks; endpoint is exact.
- MOVE exits to IDLE on the clock after the last step, with pos == target.
- TOOL:
  - tool_num = x_value (raw). tool_req=1.
  - Hold until tool_ack=1, then drop tool_req and go to IDLE.
  - Position is unchanged; the y_value target is ignored.
- Simultaneous events:
  - cmd_valid asserted in the cycle the state returns to IDLE is accepted on the next edge only (ready is registered).
  - tool_ack high before entering TOOL completes TOOL after one cycle.
- Reset mid-move: immediate return to reset values. Position is lost (pos=0), and any step pulse is cut.

Test Plan:
- Reset, then absolute G00 (state_reg=5'b00100, x=3, y=5, STEP_DIV=4) → dir_x=dir_y=1; 3 step_x and 5 step_y pulses; steps on the same ticks for the first 3; pos=(3,5); ready high again after DIR_SETUP+5 ticks.
- Absolute G01 from (0,0) to (8,4) → 8 step_x, 4 step_y; step_y on ticks 2,4,6,8; never two step_y pulses without an intervening step_x; final pos (8,4).
- Relative mm from (3,5), x=-10 (14'h3FF6), y=+2 → target clamped to (0,7); dir_x=0; 3 step_x, 2 step_y.
- Inches absolute x=2, y=1 from (0,0) → target (50,25); 50/25 steps.
- Tool change: state_reg=5'b10000, x=7 → tool_req=1, tool_num=7, no steps; ready stays 0 until 3 cycles after tool_ack rises, then 1.
- Zero-length move to the current pos → ready low exactly 2 cycles, no steps. Separately, assert rst_n=0 mid-move → all outputs return to reset values asynchronously.
